// File: rtl/two_req_rr_arbiter_pkg.sv
// rtl/two_req_rr_arbiter_pkg.sv - shared state encodings and counter width for the two-requester arbiter
package two_req_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/arb_data_mux2.sv
// rtl/arb_data_mux2.sv - DATA_W-bit 2:1 data mux carrying the last flag alongside
//
// Ports:
//   data0/last0  requester 0 beat data and last flag
//   data1/last1  requester 1 beat data and last flag
//   sel          0 selects requester 0, 1 selects requester 1
//   out_data     selected beat data
//   out_last     selected last flag
module arb_data_mux2 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data0,
    input  logic              last0,
    input  logic [DATA_W-1:0] data1,
    input  logic              last1,
    input  logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    assign out_data = sel ? data1 : data0;
    assign out_last = sel ? last1 : last0;

endmodule

// File: rtl/two_req_rr_arbiter.sv
// rtl/two_req_rr_arbiter.sv - round-robin burst arbiter sharing one output channel between two requesters
//
// Optional feature macro: ARB_TIMEOUT_EN (per-grant beat limit of MAX_BEATS with forced release).
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   req0/data0/last0       requester 0 beat request, data, last-of-burst
//   req1/data1/last1       requester 1 beat request, data, last-of-burst
//   gnt0, gnt1             channel ownership (registered, never both high)
//   ack0, ack1             beat accepted from the owning requester this cycle
//   sel                    data mux select; holds its last value while idle
//   out_valid/out_data/out_last  beat presented to the consumer
//   out_ready              consumer accepts the beat
//   timeout                one-cycle pulse after a forced grant release
module two_req_rr_arbiter
    import two_req_rr_arbiter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    input  logic              last0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    input  logic              last1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              timeout
);

    if (MAX_BEATS < 2 || MAX_BEATS > 255) begin : g_bad_max_beats
        $error("MAX_BEATS must lie in 2..255");
    end

    arb_state_t        state;
    arb_state_t        state_next;
    logic              ptr;
    logic              ptr_next;
    logic              sel_q;
    logic              busy;
    logic [DATA_W-1:0] mux_data;
    logic              mux_last;
    logic              force_last;
    logic              xfer;
    logic              burst_end;

    assign gnt0 = (state == ARB_GNT0);
    assign gnt1 = (state == ARB_GNT1);
    assign busy = gnt0 | gnt1;

    // While idle the select keeps pointing at the previous owner.
    assign sel = gnt1 | (~gnt0 & sel_q);

    arb_data_mux2 #(.DATA_W(DATA_W)) u_mux (
        .data0    (data0),
        .last0    (last0),
        .data1    (data1),
        .last1    (last1),
        .sel      (sel),
        .out_data (mux_data),
        .out_last (mux_last)
    );

    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign ack0      = gnt0 & req0 & out_ready;
    assign ack1      = gnt1 & req1 & out_ready;
    // Gate the channel with the grant so nothing leaks out while idle or in reset.
    assign out_data  = busy ? mux_data : '0;
    assign out_last  = busy & (mux_last | force_last);
    assign xfer      = out_valid & out_ready;
    assign burst_end = xfer & out_last;

`ifdef ARB_TIMEOUT_EN
    localparam logic [ARB_CNT_W-1:0] LAST_CNT = ARB_CNT_W'(MAX_BEATS - 1);

    logic [ARB_CNT_W-1:0] beat_cnt;
    logic                 timeout_q;

    // The beat that would reach the limit is flagged last so the consumer sees a closed burst.
    assign force_last = busy & (beat_cnt == LAST_CNT);
    assign timeout    = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            // Only a release that the requester did not ask for counts as a timeout.
            timeout_q <= burst_end & ~mux_last;
            if (!busy || burst_end) begin
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
`else
    assign force_last = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        unique case (state)
            ARB_IDLE: begin
                // On contention ptr names the requester whose turn it is.
                if (req0 && (!req1 || !ptr)) begin
                    state_next = ARB_GNT0;
                end else if (req1) begin
                    state_next = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (burst_end) begin
                    state_next = ARB_IDLE;
                    ptr_next   = 1'b1;
                end
            end
            ARB_GNT1: begin
                if (burst_end) begin
                    state_next = ARB_IDLE;
                    ptr_next   = 1'b0;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            ptr   <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_two_req_rr_arbiter.sv
// tb/tb_two_req_rr_arbiter.sv - directed self-checking bench for two_req_rr_arbiter
module tb_two_req_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, last0, req1, last1, out_ready;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, ack0, ack1, sel, out_valid, out_last, timeout;
    logic [7:0] out_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    two_req_rr_arbiter #(.DATA_W(8), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .data0     (data0),
        .last0     (last0),
        .req1      (req1),
        .data1     (data1),
        .last1     (last1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .timeout   (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; last0 = 0; data0 = 8'h00;
        req1 = 0; last1 = 0; data1 = 8'h00;
        out_ready = 1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        req0 = 1; req1 = 1; data0 = 8'h5A; data1 = 8'hC3; last0 = 1; last1 = 1;
        rst_n = 0;
        tick();
        tick();
        tests_run++;
        if ({gnt0, gnt1, ack0, ack1, sel, out_valid, out_last, timeout} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {gnt0, gnt1, ack0, ack1, sel, out_valid, out_last, timeout});
        end
        tests_run++;
        if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", out_data); end
        clear_inputs();
        rst_n = 1;
        #1;
    endtask

    task automatic test_single_burst();
        do_reset();
        req0 = 1; data0 = 8'hA1; last0 = 0;
        #1;
        tests_run++;
        if (gnt0 !== 1'b0) begin tests_failed++; $display("FAIL burst_gnt_latency: got %b expected 0", gnt0); end
        tick();
        tests_run++;
        if ({gnt0, out_valid, ack0, sel, out_data} !== {4'b1110, 8'hA1}) begin
            tests_failed++; $display("FAIL burst_beat1: got %b expected %b", {gnt0, out_valid, ack0, sel, out_data}, {4'b1110, 8'hA1});
        end
        tick();
        data0 = 8'hA2;
        #1;
        tests_run++;
        if ({gnt0, out_data, out_last} !== {1'b1, 8'hA2, 1'b0}) begin
            tests_failed++; $display("FAIL burst_beat2: got %b expected %b", {gnt0, out_data, out_last}, {1'b1, 8'hA2, 1'b0});
        end
        tick();
        data0 = 8'hA3; last0 = 1;
        #1;
        tests_run++;
        if ({gnt0, ack0, out_data, out_last} !== {2'b11, 8'hA3, 1'b1}) begin
            tests_failed++; $display("FAIL burst_beat3: got %b expected %b", {gnt0, ack0, out_data, out_last}, {2'b11, 8'hA3, 1'b1});
        end
        tick();
        req0 = 0; last0 = 0;
        #1;
        tests_run++;
        if ({gnt0, gnt1, out_valid, sel} !== 4'b0000) begin
            tests_failed++; $display("FAIL burst_release: got %b expected 0000", {gnt0, gnt1, out_valid, sel});
        end
        // ptr should now favour requester 1 on contention
        req0 = 1; req1 = 1; last0 = 1; last1 = 1; data1 = 8'hB1;
        tick();
        tests_run++;
        if ({gnt0, gnt1, sel, ack0, out_data} !== {4'b0110, 8'hB1}) begin
            tests_failed++; $display("FAIL burst_ptr_after: got %b expected %b", {gnt0, gnt1, sel, ack0, out_data}, {4'b0110, 8'hB1});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_alternation();
        do_reset();
        req0 = 1; req1 = 1; last0 = 1; last1 = 1; data0 = 8'h10; data1 = 8'h20;
        tick();
        tests_run++;
        if ({gnt0, gnt1} !== 2'b10) begin tests_failed++; $display("FAIL alt_first: got %b expected 10", {gnt0, gnt1}); end
        tick();
        tests_run++;
        if ({gnt0, gnt1, out_valid} !== 3'b000) begin tests_failed++; $display("FAIL alt_bubble1: got %b expected 000", {gnt0, gnt1, out_valid}); end
        tick();
        tests_run++;
        if ({gnt0, gnt1, out_data} !== {2'b01, 8'h20}) begin tests_failed++; $display("FAIL alt_second: got %b expected %b", {gnt0, gnt1, out_data}, {2'b01, 8'h20}); end
        tick();
        tests_run++;
        if ({gnt0, gnt1, sel} !== 3'b001) begin tests_failed++; $display("FAIL alt_bubble2_sel_hold: got %b expected 001", {gnt0, gnt1, sel}); end
        tick();
        tests_run++;
        if ({gnt0, gnt1} !== 2'b10) begin tests_failed++; $display("FAIL alt_third: got %b expected 10", {gnt0, gnt1}); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req1 = 1; data1 = 8'hD1; last1 = 0; out_ready = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({gnt1, out_valid, ack1, out_data} !== {3'b110, 8'hD1}) begin
                tests_failed++; $display("FAIL bp_stall%0d: got %b expected %b", i, {gnt1, out_valid, ack1, out_data}, {3'b110, 8'hD1});
            end
            if (i < 3) tick();
        end
        out_ready = 1;
        #1;
        tests_run++;
        if (ack1 !== 1'b1) begin tests_failed++; $display("FAIL bp_ack_resume: got %b expected 1", ack1); end
        tick();
        data1 = 8'hD2; last1 = 1;
        #1;
        tests_run++;
        if ({gnt1, out_data, out_last} !== {1'b1, 8'hD2, 1'b1}) begin
            tests_failed++; $display("FAIL bp_beat2: got %b expected %b", {gnt1, out_data, out_last}, {1'b1, 8'hD2, 1'b1});
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (gnt1 !== 1'b0) begin tests_failed++; $display("FAIL bp_release: got %b expected 0", gnt1); end
        tick();
    endtask

    task automatic test_req_drop();
        do_reset();
        req0 = 1; data0 = 8'hE1; last0 = 0; req1 = 1; last1 = 1;
        tick();
        tick();
        req0 = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if ({gnt0, gnt1, out_valid, ack0} !== 4'b1000) begin
                tests_failed++; $display("FAIL drop_hold%0d: got %b expected 1000", i, {gnt0, gnt1, out_valid, ack0});
            end
            tick();
        end
        req0 = 1; data0 = 8'hE2; last0 = 1;
        #1;
        tests_run++;
        if ({gnt0, out_valid, out_last, out_data} !== {3'b111, 8'hE2}) begin
            tests_failed++; $display("FAIL drop_resume: got %b expected %b", {gnt0, out_valid, out_last, out_data}, {3'b111, 8'hE2});
        end
        tick();
        req0 = 0; last0 = 0;
        tick();
        tests_run++;
        if ({gnt0, gnt1} !== 2'b01) begin tests_failed++; $display("FAIL drop_next_owner: got %b expected 01", {gnt0, gnt1}); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req0 = 1; last0 = 1; data0 = 8'h31;
        tick();
        tick();
        req0 = 0; last0 = 0; req1 = 1; last1 = 0; data1 = 8'h41;
        tick();
        tick();
        #2;
        rst_n = 0;
        #1;
        tests_run++;
        if ({gnt0, gnt1, ack0, ack1, sel, out_valid, out_last, timeout, out_data} !== 16'h0000) begin
            tests_failed++; $display("FAIL async_reset_outputs: got %h expected 0000", {gnt0, gnt1, ack0, ack1, sel, out_valid, out_last, timeout, out_data});
        end
        #1;
        rst_n = 1;
        req0 = 1; last0 = 1; last1 = 1;
        tick();
        tests_run++;
        if ({gnt0, gnt1} !== 2'b10) begin tests_failed++; $display("FAIL async_reset_ptr: got %b expected 10", {gnt0, gnt1}); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req1 = 1; last1 = 0; data1 = 8'h60;
        tick();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({gnt1, out_last, timeout} !== 3'b100) begin
                tests_failed++; $display("FAIL to_beat%0d: got %b expected 100", i, {gnt1, out_last, timeout});
            end
            tick();
            data1 = data1 + 8'h01;
            #1;
        end
`ifdef ARB_TIMEOUT_EN
        tests_run++;
        if ({gnt1, out_last, timeout} !== 3'b110) begin tests_failed++; $display("FAIL to_forced_last: got %b expected 110", {gnt1, out_last, timeout}); end
        tick();
        tests_run++;
        if ({gnt1, timeout} !== 2'b01) begin tests_failed++; $display("FAIL to_release_pulse: got %b expected 01", {gnt1, timeout}); end
        tick();
        tests_run++;
        if ({gnt1, timeout} !== 2'b10) begin tests_failed++; $display("FAIL to_pulse_width: got %b expected 10", {gnt1, timeout}); end
`else
        for (int i = 3; i < 6; i++) begin
            tests_run++;
            if ({gnt1, out_last, timeout} !== 3'b100) begin
                tests_failed++; $display("FAIL to_persist%0d: got %b expected 100", i, {gnt1, out_last, timeout});
            end
            tick();
        end
`endif
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_alternation();
        test_backpressure();
        test_req_drop();
        test_async_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
